abc_vector_seq: RTL and testbench
=================================

ABC_VECTOR_SEQ -- requirements
Module: abc_vector_seq

Interface
REQ-001 Parameter DWELL, default 10, cycles each vector is driven before its response is sampled; legal range 1..255.
REQ-002 Parameter NVEC, default 4, number of vectors per run; legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; honoured only in IDLE.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 d  input  1  first response bit from the downstream block under stimulus.
REQ-008 e  input  1  second response bit from the downstream block under stimulus.
REQ-009 a  output  1  stimulus bit, vector index bit 2.
REQ-010 b  output  1  stimulus bit, vector index bit 1.
REQ-011 c  output  1  stimulus bit, vector index bit 0.
REQ-012 busy  output  1  high in DRIVE and SAMPLE.
REQ-013 done  output  1  one-cycle pulse on run completion.
REQ-014 log  output  16  captured responses, {d,e} of vector i in bits [2i+1:2i].

Function
REQ-015 Design is a 4-state FSM, IDLE, DRIVE, SAMPLE and DONE, with an 8-bit dwell counter, a 3-bit vector index vec, and a 16-bit log register; all outputs are registered.
REQ-016 {a,b,c} SHALL equal vec in DRIVE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-017 IDLE with start=1 and abort=0: next edge goes to DRIVE, sets vec=0 and counter=0, and clears log to 0.
REQ-018 DRIVE: counter increments each cycle; on the edge where counter==DWELL-1, go to SAMPLE.
REQ-019 SAMPLE lasts exactly one cycle; on its exiting edge, log[2*vec+1:2*vec] <= {d,e}.
REQ-020 On that same SAMPLE-exiting edge: if vec==NVEC-1, go to DONE; else vec <= vec+1, counter <= 0, go to DRIVE.
REQ-021 Each vector is driven for exactly DWELL+1 cycles; a run keeps busy high for NVEC*(DWELL+1) cycles.
REQ-022 DONE lasts one cycle with done=1, then goes to IDLE.
REQ-023 log holds its value through DONE and IDLE until the next accepted start.
REQ-024 start asserted outside IDLE is ignored and not queued.
REQ-025 abort=1 in DRIVE or SAMPLE: next edge goes to IDLE with {a,b,c}=0, busy=0, no done pulse, and log retaining entries captured so far.
REQ-026 If abort and the SAMPLE-exit capture coincide, abort wins and that capture is discarded.
REQ-027 abort in IDLE or DONE has no effect; start and abort together in IDLE stay in IDLE.
REQ-028 log bits above 2*NVEC-1 remain 0.

Reset
REQ-029 rst=1 at a rising edge forces IDLE, with vec=0, counter=0, log=0, {a,b,c}=0, busy=0 and done=0.
REQ-030 rst has priority over start and abort in every state.
REQ-031 rst mid-run discards the run: no done pulse and log cleared.

Verification
REQ-032 Nominal run. DWELL=2, NVEC=4, d=b|c, e=a&b, 1-cycle start pulse: abc steps 000,001,010,011, each held 3 cycles; busy high 12 cycles; done pulses once; log=16'h00A8.
REQ-033 Full sweep. NVEC=8, DWELL=1, d=a^b^c, e=0: abc steps 000..111, each held 2 cycles; log=16'h8228.
REQ-034 Start while busy. start held high through the whole nominal run: exactly one run of 12 busy cycles, then a new run begins the cycle after DONE, with log cleared.
REQ-035 Abort. abort asserted in the 2nd DRIVE cycle of vector 2, nominal setup: next cycle IDLE with abc=000; no done pulse; log=16'h0008.
REQ-036 Reset mid-run. rst in the SAMPLE cycle of vector 1: next cycle all outputs are 0 and log=0; a following start yields the nominal result 16'h00A8.
REQ-037 Minimum run. NVEC=1, DWELL=1, d=1, e=1: busy high 2 cycles, done pulses once, log=16'h0003.

Source files
------------

// File: rtl/abc_vector_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : abc_vector_seq_if
//  Description : Run control, response and stimulus/result signals of the
//                abc vector sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface abc_vector_seq_if;
    logic        start;
    logic        abort;
    logic        d;
    logic        e;
    logic        a;
    logic        b;
    logic        c;
    logic        busy;
    logic        done;
    logic [15:0] log;

    // The controlling side drives run requests and the block-under-test responses
    modport master (
        output start, abort, d, e,
        input  a, b, c, busy, done, log
    );

    // The sequencer consumes requests/responses and produces stimulus and results
    modport slave (
        input  start, abort, d, e,
        output a, b, c, busy, done, log
    );
endinterface
`default_nettype wire

// File: rtl/abc_vector_seq.sv
`default_nettype none
// ============================================================================
//  Module      : abc_vector_seq
//  Description : Steps a 3-bit stimulus vector {a,b,c} through 0..NVEC-1,
//                holds each for DWELL+1 cycles, and captures the {d,e}
//                response of every vector into a 16-bit log.
//  Revision    : 1.0  initial release
// ============================================================================
module abc_vector_seq #(
    parameter int DWELL = 10,   // 1..255
    parameter int NVEC  = 4     // 1..8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    abc_vector_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] c_dwell_last = 8'(DWELL - 1);
    localparam logic [2:0] c_vec_last   = 3'(NVEC - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_vec;
    logic [15:0] r_log;
    logic [2:0]  r_abc;
    logic        r_busy;
    logic        r_done;

    // Sequencer FSM; every output is registered alongside the state so that
    // {a,b,c} and busy change on exactly the same edge as the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_vec   <= 3'd0;
            r_log   <= 16'd0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // start together with abort is deliberately not accepted
                    if (bus.start && !bus.abort) begin
                        r_state <= S_DRIVE;
                        r_vec   <= 3'd0;
                        r_cnt   <= 8'd0;
                        r_log   <= 16'd0;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_dwell_last) begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    // abort beats the capture: the pending response is dropped
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_log[{r_vec, 1'b0} +: 2] <= {bus.d, bus.e};
                        if (r_vec == c_vec_last) begin
                            r_state <= S_DONE;
                            r_abc   <= 3'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRIVE;
                            r_vec   <= r_vec + 3'd1;
                            r_abc   <= r_vec + 3'd1;
                            r_cnt   <= 8'd0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_abc   <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a    = r_abc[2];
    assign bus.b    = r_abc[1];
    assign bus.c    = r_abc[0];
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.log  = r_log;

endmodule
`default_nettype wire

// File: tb/tb_abc_vector_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_abc_vector_seq
//  Description : Directed bench for abc_vector_seq with three configurations
//                (nominal 4x2, sweep 8x1, minimum 1x1) and a queue scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_abc_vector_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] st;
    logic [2:0] ab;
    int         sel;
    int         errors = 0;
    int         checks = 0;

    logic [2:0]  abc_q[$];
    logic [15:0] log_q[$];

    logic [2:0]  obs_abc;
    logic        obs_busy;
    logic        obs_done;
    logic [15:0] obs_log;

    always #5 clk = ~clk;

    abc_vector_seq_if if_nom ();
    abc_vector_seq_if if_swp ();
    abc_vector_seq_if if_min ();

    // Run requests from the directed sequence below
    assign if_nom.start = st[0];
    assign if_nom.abort = ab[0];
    assign if_swp.start = st[1];
    assign if_swp.abort = ab[1];
    assign if_min.start = st[2];
    assign if_min.abort = ab[2];

    // Models of the downstream blocks under stimulus
    assign if_nom.d = if_nom.b | if_nom.c;
    assign if_nom.e = if_nom.a & if_nom.b;
    assign if_swp.d = if_swp.a ^ if_swp.b ^ if_swp.c;
    assign if_swp.e = 1'b0;
    assign if_min.d = 1'b1;
    assign if_min.e = 1'b1;

    abc_vector_seq #(.DWELL(2), .NVEC(4)) u_nom (.clk(clk), .rst(rst), .bus(if_nom));
    abc_vector_seq #(.DWELL(1), .NVEC(8)) u_swp (.clk(clk), .rst(rst), .bus(if_swp));
    abc_vector_seq #(.DWELL(1), .NVEC(1)) u_min (.clk(clk), .rst(rst), .bus(if_min));

    // Route the selected instance to the checker
    always_comb begin
        obs_abc  = 3'd0;
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_log  = 16'd0;
        case (sel)
            0: begin
                obs_abc = {if_nom.a, if_nom.b, if_nom.c}; obs_busy = if_nom.busy;
                obs_done = if_nom.done; obs_log = if_nom.log;
            end
            1: begin
                obs_abc = {if_swp.a, if_swp.b, if_swp.c}; obs_busy = if_swp.busy;
                obs_done = if_swp.done; obs_log = if_swp.log;
            end
            default: begin
                obs_abc = {if_min.a, if_min.b, if_min.c}; obs_busy = if_min.busy;
                obs_done = if_min.done; obs_log = if_min.log;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic view(input int s);
        sel = s;
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {a,b,c} for every busy cycle of a full run
    task automatic push_run(input int nvec, input int dwell);
        for (int v = 0; v < nvec; v++)
            for (int k = 0; k <= dwell; k++)
                abc_q.push_back(3'(v));
    endtask

    task automatic pulse_start(input int s, input bit hold);
        st[s] = 1'b1;
        tick();
        if (!hold) st[s] = 1'b0;
    endtask

    // Compare n consecutive busy cycles against the scoreboard
    task automatic step_busy(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (abc_q.size() > 0) else begin
                errors++;
                $error("FAIL abc_q_underflow: observed=0 expected=entry");
            end
            chk("busy_run", 16'(obs_busy), 16'd1);
            chk("done_run", 16'(obs_done), 16'd0);
            if (abc_q.size() > 0) chk("abc_run", 16'(obs_abc), 16'(abc_q.pop_front()));
            tick();
        end
    endtask

    task automatic done_check();
        chk("done_pulse", 16'(obs_done), 16'd1);
        chk("busy_done", 16'(obs_busy), 16'd0);
        chk("abc_done", 16'(obs_abc), 16'd0);
        if (log_q.size() > 0) chk("log_done", obs_log, log_q.pop_front());
        else chk("log_q_underflow", 16'd0, 16'd1);
    endtask

    // Abort the nominal run in busy cycle n (0-based)
    task automatic abort_at(input int n);
        step_busy(n);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        abc_q.delete();
        chk("busy_abort", 16'(obs_busy), 16'd0);
        chk("abc_abort", 16'(obs_abc), 16'd0);
        chk("done_abort", 16'(obs_done), 16'd0);
        if (log_q.size() > 0) chk("log_abort", obs_log, log_q.pop_front());
        else chk("log_q_underflow", 16'd0, 16'd1);
        tick();
        chk("done_after_abort", 16'(obs_done), 16'd0);
        chk("busy_after_abort", 16'(obs_busy), 16'd0);
    endtask

    initial begin
        sel = 0;
        rst = 1'b1;
        st  = 3'b000;
        ab  = 3'b000;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            view(s);
            chk("rst_abc", 16'(obs_abc), 16'd0);
            chk("rst_busy", 16'(obs_busy), 16'd0);
            chk("rst_done", 16'(obs_done), 16'd0);
            chk("rst_log", obs_log, 16'd0);
        end

        // Nominal run
        view(0);
        log_q.push_back(16'h00A8);
        push_run(4, 2);
        pulse_start(0, 1'b0);
        step_busy(12);
        done_check();
        tick();
        chk("done_once", 16'(obs_done), 16'd0);
        chk("log_hold", obs_log, 16'h00A8);

        // Full sweep of all eight vectors
        view(1);
        log_q.push_back(16'h8228);
        push_run(8, 1);
        pulse_start(1, 1'b0);
        step_busy(16);
        done_check();
        tick();
        chk("swp_done_once", 16'(obs_done), 16'd0);

        // Minimum run
        view(2);
        log_q.push_back(16'h0003);
        push_run(1, 1);
        pulse_start(2, 1'b0);
        step_busy(2);
        done_check();
        tick();
        chk("min_idle_busy", 16'(obs_busy), 16'd0);

        // start held through a whole run: one run, then restart via IDLE
        view(0);
        log_q.push_back(16'h00A8);
        push_run(4, 2);
        pulse_start(0, 1'b1);
        step_busy(12);
        done_check();
        tick();
        chk("held_idle_busy", 16'(obs_busy), 16'd0);
        chk("held_idle_log", obs_log, 16'h00A8);
        tick();
        chk("held_restart_busy", 16'(obs_busy), 16'd1);
        chk("held_restart_abc", 16'(obs_abc), 16'd0);
        chk("held_restart_log", obs_log, 16'd0);
        st[0] = 1'b0;
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        chk("held_abort_busy", 16'(obs_busy), 16'd0);
        tick();

        // Abort in the 2nd DRIVE cycle of vector 2
        log_q.push_back(16'h0008);
        push_run(4, 2);
        pulse_start(0, 1'b0);
        abort_at(7);

        // Abort coinciding with the SAMPLE capture of vector 2
        log_q.push_back(16'h0008);
        push_run(4, 2);
        pulse_start(0, 1'b0);
        abort_at(8);

        // abort alone and start+abort in IDLE are both inert
        ab[0] = 1'b1;
        tick();
        chk("idle_abort_busy", 16'(obs_busy), 16'd0);
        chk("idle_abort_log", obs_log, 16'h0008);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        ab[0] = 1'b0;
        chk("start_abort_busy", 16'(obs_busy), 16'd0);
        tick();
        chk("start_abort_busy2", 16'(obs_busy), 16'd0);

        // Reset in the SAMPLE cycle of vector 1, then a clean run
        push_run(4, 2);
        pulse_start(0, 1'b0);
        step_busy(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        abc_q.delete();
        chk("mid_rst_abc", 16'(obs_abc), 16'd0);
        chk("mid_rst_busy", 16'(obs_busy), 16'd0);
        chk("mid_rst_done", 16'(obs_done), 16'd0);
        chk("mid_rst_log", obs_log, 16'd0);
        tick();
        chk("mid_rst_no_done", 16'(obs_done), 16'd0);
        log_q.push_back(16'h00A8);
        push_run(4, 2);
        pulse_start(0, 1'b0);
        step_busy(12);
        done_check();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
